crusher_scheduler: RTL

//  Time-shares one bitcrusher datapath (start/done handshake, 12-bit samples) among NUM_CH drum-pad

---
 rtl/crusher_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/crusher_scheduler.sv
// crusher_scheduler
//   Time-shares a single bitcrusher datapath among NUM_CH drum-pad sample
//   channels. Requests are granted round-robin, the chosen sample is handed to
//   the crusher with a one-cycle start pulse, and the crushed result comes back
//   tagged with its channel number. If the crusher never signals done, a
//   watchdog forwards the original sample and flags the bypass.
//
// Ports
//   clock         system clock, rising edge
//   reset         synchronous, active-high
//   req_valid     per-channel request, held until req_ack
//   req_sample    packed samples, channel i at [12*i+11:12*i]
//   req_ack       one-hot 1-cycle pulse: that channel's sample was taken
//   crush_start   1-cycle start pulse to the bitcrusher
//   crush_sample  sample under processing, held until the next grant
//   crush_result  bitcrusher output, valid with crush_done
//   crush_done    bitcrusher completion
//   out_valid     1-cycle pulse: out_sample/out_ch valid
//   out_sample    crushed or bypassed sample, held until the next result
//   out_ch        channel that produced out_sample
//   timeout_err   1-cycle pulse with out_valid when the crusher was bypassed
module crusher_scheduler #(
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 255,
  localparam int NUM_CH = 2 ** CH_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH*12-1:0] req_sample,
  output logic [NUM_CH-1:0]    req_ack,
  output logic                 crush_start,
  output logic [11:0]          crush_sample,
  input  logic [11:0]          crush_result,
  input  logic                 crush_done,
  output logic                 out_valid,
  output logic [11:0]          out_sample,
  output logic [CH_W-1:0]      out_ch,
  output logic                 timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic                start_q, start_d;
  logic [11:0]         crush_sample_q, crush_sample_d;
  logic                out_valid_q, out_valid_d;
  logic [11:0]         out_sample_q, out_sample_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic                timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                arbFound;
  logic [CH_W-1:0]     arbIdx;

  // Round-robin search starting at rr_ptr. Offsets are scanned from the
  // farthest down to zero so the closest pending channel is written last and
  // therefore wins.
  always_comb begin
    logic [CH_W-1:0] probe;
    probe    = '0;
    arbFound = 1'b0;
    arbIdx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      probe = rr_ptr_q + CH_W'(i);
      if (req_valid[probe]) begin
        arbFound = 1'b1;
        arbIdx   = probe;
      end
    end
  end

  // Next-state and output logic. Every output is registered: the pulse
  // outputs are loaded on the transition into the state in which they must be
  // seen, so req_ack/crush_start are high during ISSUE and out_valid/
  // timeout_err are high during OUT. The timeout_err register doubles as the
  // bypass flag and is cleared by its default when OUT is left.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    ack_d          = '0;
    start_d        = 1'b0;
    crush_sample_d = crush_sample_q;
    out_valid_d    = 1'b0;
    out_sample_d   = out_sample_q;
    out_ch_d       = out_ch_q;
    timeout_err_d  = 1'b0;
    cnt_d          = cnt_q;

    case (state_q)
      IDLE: begin
        if (arbFound) begin
          grant_d        = arbIdx;
          crush_sample_d = req_sample[int'(arbIdx) * 12 +: 12];
          ack_d          = NUM_CH'(1) << arbIdx;
          start_d        = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (crush_done) begin
          out_sample_d = crush_result;
          out_ch_d     = grant_q;
          out_valid_d  = 1'b1;
          state_d      = OUT;
        end else if (cnt_q == CNT_LAST) begin
          out_sample_d  = crush_sample_q;
          out_ch_d      = grant_q;
          out_valid_d   = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OUT: begin
        rr_ptr_d = grant_q + CH_W'(1);
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; a reset in the middle
  // of a transaction simply drops it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      ack_q          <= '0;
      start_q        <= 1'b0;
      crush_sample_q <= '0;
      out_valid_q    <= 1'b0;
      out_sample_q   <= '0;
      out_ch_q       <= '0;
      timeout_err_q  <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      ack_q          <= ack_d;
      start_q        <= start_d;
      crush_sample_q <= crush_sample_d;
      out_valid_q    <= out_valid_d;
      out_sample_q   <= out_sample_d;
      out_ch_q       <= out_ch_d;
      timeout_err_q  <= timeout_err_d;
      cnt_q          <= cnt_d;
    end
  end

  assign req_ack      = ack_q;
  assign crush_start  = start_q;
  assign crush_sample = crush_sample_q;
  assign out_valid    = out_valid_q;
  assign out_sample   = out_sample_q;
  assign out_ch       = out_ch_q;
  assign timeout_err  = timeout_err_q;

endmodule
